// File: rtl/fpu_addsub_mc.sv
// fpu_addsub_mc: multi-cycle adder/subtractor for the 1/7/24 custom float (bias 63).
// Define FPU_RNE_EN for round-to-nearest-even; the default build truncates.
module fpu_addsub_mc (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a_in,
    input  logic [31:0] op_b_in,
    input  logic        op_sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);
    localparam int unsigned EW  = 7;
    localparam int unsigned FW  = 24;
    localparam int unsigned MW  = FW + 1;
    localparam int unsigned XW  = MW + 3;
    localparam int unsigned SW  = XW + 1;
    localparam int unsigned XEW = 9;
    localparam logic [EW-1:0] EXP_MAX = 7'h7F;

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_t;

    state_t state_q, state_d;
    logic   cap_c, align_c, add_c, norm_c, round_c, busy_d, done_d;

    logic                  busy_q, done_q;
    logic [31:0]           data_q;
    logic [3:0]            status_q;
    logic                  big_s_q, sml_s_q, inf_q, inf_s_q, zero_q;
    logic [EW-1:0]         big_e_q, sml_e_q;
    logic [MW-1:0]         big_m_q, sml_m_q;
    logic [XW-1:0]         sml_x_q, norm_m_q;
    logic [SW-1:0]         sum_q;
    logic signed [XEW-1:0] exp_q;

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: stage enables and next values of the status flops
    always_comb begin
        cap_c   = 1'b0;
        align_c = 1'b0;
        add_c   = 1'b0;
        norm_c  = 1'b0;
        round_c = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:  begin cap_c = start; busy_d = start; end
            S_ALIGN: begin align_c = 1'b1; busy_d = 1'b1; end
            S_ADD:   begin add_c = 1'b1; busy_d = 1'b1; end
            S_NORM:  begin norm_c = 1'b1; busy_d = 1'b1; end
            S_ROUND: begin round_c = 1'b1; done_d = 1'b1; end
            default: ;
        endcase
    end

    // Unpack with flush-to-zero; B's sign is flipped for subtraction
    logic          a_s, b_s, a_inf, b_inf, swap_c;
    logic [EW-1:0] a_e, b_e;
    logic [MW-1:0] a_m, b_m;
    always_comb begin
        a_s    = op_a_in[31];
        b_s    = op_b_in[31] ^ op_sel;
        a_e    = op_a_in[30:24];
        b_e    = op_b_in[30:24];
        a_m    = (a_e == '0) ? '0 : {1'b1, op_a_in[FW-1:0]};
        b_m    = (b_e == '0) ? '0 : {1'b1, op_b_in[FW-1:0]};
        a_inf  = (a_e == EXP_MAX);
        b_inf  = (b_e == EXP_MAX);
        swap_c = ({b_e, b_m} > {a_e, a_m});
    end

    // Align: shifted-out bits collapse into the sticky position
    logic [EW-1:0] diff_c;
    logic [4:0]    sh_c;
    logic [XW-1:0] sx_c, shout_c, lost_c, aligned_c;
    always_comb begin
        diff_c    = big_e_q - sml_e_q;
        sh_c      = (diff_c > 7'd27) ? 5'd27 : diff_c[4:0];
        sx_c      = {sml_m_q, 3'b000};
        shout_c   = sx_c >> sh_c;
        lost_c    = sx_c & ~({XW{1'b1}} << sh_c);
        aligned_c = {shout_c[XW-1:1], shout_c[0] | (|lost_c)};
    end

    logic [SW-1:0] sum_c;
    always_comb begin
        if (big_s_q == sml_s_q) sum_c = {1'b0, big_m_q, 3'b000} + {1'b0, sml_x_q};
        else                    sum_c = {1'b0, big_m_q, 3'b000} - {1'b0, sml_x_q};
    end

    // Normalize: carry shifts right, otherwise leading-zero shift left
    logic [4:0]            lz_c;
    logic [XW-1:0]         norm_c_m;
    logic signed [XEW-1:0] exp_c;
    always_comb begin
        lz_c = 5'd0;
        for (int i = 0; i < int'(XW); i++)
            if (sum_q[i]) lz_c = 5'(int'(XW) - 1 - i);
        if (sum_q[SW-1]) begin
            norm_c_m = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
            exp_c    = $signed({2'b00, big_e_q}) + 9'sd1;
        end else begin
            norm_c_m = sum_q[XW-1:0] << lz_c;
            exp_c    = $signed({2'b00, big_e_q}) - $signed({4'b0000, lz_c});
        end
    end

    // Round and classify
    logic                  inc_c, inexact_c;
    logic [MW:0]           rnd_c;
    logic [FW-1:0]         frac_c;
    logic signed [XEW-1:0] exp_r_c;
    logic [31:0]           res_c;
    logic [3:0]            st_c;
    always_comb begin
        inexact_c = |norm_m_q[2:0];
`ifdef FPU_RNE_EN
        inc_c = norm_m_q[2] & (norm_m_q[1] | norm_m_q[0] | norm_m_q[3]);
`else
        inc_c = 1'b0;
`endif
        rnd_c = {1'b0, norm_m_q[XW-1:3]} + {{MW{1'b0}}, inc_c};
        if (rnd_c[MW]) begin
            frac_c  = rnd_c[FW:1];
            exp_r_c = exp_q + 9'sd1;
        end else begin
            frac_c  = rnd_c[FW-1:0];
            exp_r_c = exp_q;
        end
        if (inf_q) begin
            res_c = {inf_s_q, EXP_MAX, 24'h0};           st_c = 4'b0010;
        end else if (zero_q) begin
            res_c = 32'h0;                               st_c = 4'b0001;
        end else if (exp_r_c >= 9'sd127) begin
            res_c = {big_s_q, EXP_MAX, 24'h0};           st_c = 4'b0010;
        end else if (exp_r_c <= 9'sd0) begin
            res_c = {big_s_q, 31'h0};                    st_c = 4'b0100;
        end else begin
            res_c = {big_s_q, exp_r_c[EW-1:0], frac_c};
            st_c  = inexact_c ? 4'b1000 : 4'b0001;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= 1'b0;  done_q <= 1'b0;  data_q <= '0;  status_q <= '0;
            big_s_q <= 1'b0; sml_s_q <= 1'b0; inf_q <= 1'b0; inf_s_q <= 1'b0;
            big_e_q <= '0;   sml_e_q <= '0;   big_m_q <= '0; sml_m_q <= '0;
            sml_x_q <= '0;   sum_q <= '0;     norm_m_q <= '0; exp_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (cap_c) begin
                big_s_q <= swap_c ? b_s : a_s;
                big_e_q <= swap_c ? b_e : a_e;
                big_m_q <= swap_c ? b_m : a_m;
                sml_s_q <= swap_c ? a_s : b_s;
                sml_e_q <= swap_c ? a_e : b_e;
                sml_m_q <= swap_c ? a_m : b_m;
                inf_q   <= a_inf | b_inf;
                inf_s_q <= a_inf ? a_s : b_s;
            end
            if (align_c) sml_x_q <= aligned_c;
            if (add_c)   sum_q   <= sum_c;
            if (norm_c) begin
                norm_m_q <= norm_c_m;
                exp_q    <= exp_c;
                zero_q   <= (sum_q == '0);
            end
            if (round_c) begin
                data_q   <= res_c;
                status_q <= st_c;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign data_out   = data_q;
    assign status_out = status_q;
endmodule

// File: tb/tb_fpu_addsub_mc.sv
// tb_fpu_addsub_mc: scoreboard bench for fpu_addsub_mc (either FPU_RNE_EN setting).
module tb_fpu_addsub_mc;
    logic        clk = 1'b0;
    logic        rst, start, op_sel, busy, done;
    logic [31:0] op_a_in, op_b_in, data_out;
    logic [3:0]  status_out;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  status;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
        logic [31:0] data;
        logic [3:0]  status;
    } case_t;

    exp_t sb_q[$];

`ifdef FPU_RNE_EN
    localparam logic [31:0] RND3 = 32'h40000002;
`else
    localparam logic [31:0] RND3 = 32'h40000001;
`endif

    always #5 clk = ~clk;

    fpu_addsub_mc dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a_in    (op_a_in),
        .op_b_in    (op_b_in),
        .op_sel     (op_sel),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .status_out (status_out)
    );

    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic sel);
        @(negedge clk);
        op_a_in = a; op_b_in = b; op_sel = sel; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc, output bit seen);
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; op_a_in = '0; op_b_in = '0; op_sel = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_out); end
        checks++; if (status_out !== 4'h0) begin errors++; $display("FAIL reset_status got %b want 0000", status_out); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        case_t tbl[$];
        exp_t  e;
        int    cyc;
        bit    seen;
        tbl.push_back('{32'h3F000000, 32'h3F000000, 1'b0, 32'h40000000, 4'b0001});
        tbl.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001});
        tbl.push_back('{32'h3F000000, 32'h40000000, 1'b1, 32'hBF000000, 4'b0001});
        tbl.push_back('{32'h7EFFFFFF, 32'h7EFFFFFF, 1'b0, 32'h7F000000, 4'b0010});
        tbl.push_back('{32'h01800000, 32'h01000000, 1'b1, 32'h00000000, 4'b0100});
        tbl.push_back('{32'h3F000001, 32'h3F000000, 1'b0, 32'h40000000, 4'b1000});
        tbl.push_back('{32'h3F000003, 32'h3F000000, 1'b0, RND3,         4'b1000});
        tbl.push_back('{32'h40000000, 32'h00000000, 1'b0, 32'h40000000, 4'b0001});
        tbl.push_back('{32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 4'b0001});
        tbl.push_back('{32'h3F800000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0001});
        tbl.push_back('{32'h7F000000, 32'h3F000000, 1'b0, 32'h7F000000, 4'b0010});
        foreach (tbl[i]) begin
            sb_q.push_back('{tbl[i].data, tbl[i].status});
            drive_start(tbl[i].a, tbl[i].b, tbl[i].sel);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL arith%0d_busy got %b want 1", i, busy); end
            wait_done(10, cyc, seen);
            checks++;
            if (!seen || cyc != 4) begin
                errors++; $display("FAIL arith%0d_latency got %0d seen %b want 4", i, cyc, seen);
            end
            e = sb_q.pop_front();
            if (seen) begin
                checks++;
                if (data_out !== e.data) begin
                    errors++; $display("FAIL arith%0d_data got %h want %h", i, data_out, e.data);
                end
                checks++;
                if (status_out !== e.status) begin
                    errors++; $display("FAIL arith%0d_status got %b want %b", i, status_out, e.status);
                end
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL arith%0d_busy_end got %b want 0", i, busy); end
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL arith%0d_done_width got %b want 0", i, done); end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   pulses = 0;
        sb_q.push_back('{32'h40000000, 4'b0001});
        drive_start(32'h3F000000, 32'h3F000000, 1'b0);
        @(negedge clk);
        op_a_in = 32'h3F800000; op_b_in = 32'h3F800000; op_sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    e = sb_q.pop_front();
                    checks++;
                    if (data_out !== e.data || status_out !== e.status) begin
                        errors++;
                        $display("FAIL ignore_data got %h/%b want %h/%b", data_out, status_out, e.data, e.status);
                    end
                end
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d want 1", pulses); end
        if (pulses == 0) void'(sb_q.pop_front());
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        bit   seen;
        sb_q.push_back('{32'h40000000, 4'b0001});
        drive_start(32'h3F000000, 32'h3F000000, 1'b0);
        wait_done(10, cyc, seen);
        e = sb_q.pop_front();
        checks++;
        if (!seen || data_out !== e.data || status_out !== e.status) begin
            errors++; $display("FAIL b2b_first got %h/%b seen %b want %h/%b", data_out, status_out, seen, e.data, e.status);
        end
        sb_q.push_back('{32'hBF000000, 4'b0001});
        op_a_in = 32'h3F000000; op_b_in = 32'h40000000; op_sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
        wait_done(10, cyc, seen);
        e = sb_q.pop_front();
        checks++;
        if (!seen || cyc != 4) begin errors++; $display("FAIL b2b_latency got %0d seen %b want 4", cyc, seen); end
        checks++;
        if (data_out !== e.data || status_out !== e.status) begin
            errors++; $display("FAIL b2b_second got %h/%b want %h/%b", data_out, status_out, e.data, e.status);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   pulses = 0;
        int   cyc;
        bit   seen;
        drive_start(32'h3F800000, 32'h3E000000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL abort_data got %h want 0", data_out); end
        checks++; if (status_out !== 4'h0) begin errors++; $display("FAIL abort_status got %b want 0", status_out); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", pulses); end
        sb_q.push_back('{32'h40000000, 4'b0001});
        drive_start(32'h3F800000, 32'h3E000000, 1'b0);
        wait_done(10, cyc, seen);
        e = sb_q.pop_front();
        checks++;
        if (!seen || cyc != 4 || data_out !== e.data || status_out !== e.status) begin
            errors++;
            $display("FAIL abort_recover got %h/%b cyc %0d want %h/%b cyc 4", data_out, status_out, cyc, e.data, e.status);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
